// File: rtl/sauria_pkg.sv
// Shared types for the SAURIA stream checker.
// Contents: checker_mode_e (compare mode), chk_state_e (run FSM state),
// decode_mode() which maps the raw 2-bit mode input onto checker_mode_e.
package sauria_pkg;

  typedef enum logic [1:0] {
    MODE_WORD = 2'd0,
    MODE_LANE = 2'd1,
    MODE_TOL  = 2'd2
  } checker_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  // Raw encoding 3 is reserved and behaves as per-lane exact compare.
  function automatic checker_mode_e decode_mode(input logic [1:0] raw);
    checker_mode_e m;
    case (raw)
      2'd0:    m = MODE_WORD;
      2'd2:    m = MODE_TOL;
      default: m = MODE_LANE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sauria_lane_cmp.sv
// One compare lane of the stream checker, with a registered mismatch flag.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   en_i             load the mismatch register (word handshake)
//   tol_en_i         1: tolerance compare, 0: exact compare
//   tol_i            unsigned absolute tolerance
//   exp_i, acq_i     expected / acquired lane values
//   mismatch_o       registered mismatch flag for the last loaded word
module sauria_lane_cmp #(
  parameter int unsigned LANE_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              tol_en_i,
  input  logic [LANE_W-1:0] tol_i,
  input  logic [LANE_W-1:0] exp_i,
  input  logic [LANE_W-1:0] acq_i,
  output logic              mismatch_o
);

  localparam int unsigned DIFF_W = LANE_W + 1;

  logic signed [DIFF_W-1:0] diff_c;
  logic        [DIFF_W-1:0] abs_c;
  logic                     unknown_c;
  logic                     mismatch_d, mismatch_q;

  // Any X/Z bit in acquired data counts as a mismatch in simulation.
`ifdef SYNTHESIS
  assign unknown_c = 1'b0;
`else
  assign unknown_c = $isunknown(acq_i);
`endif

  // Signed difference one bit wider than the lane so it can never overflow.
  always_comb begin
    diff_c     = $signed({exp_i[LANE_W-1], exp_i}) - $signed({acq_i[LANE_W-1], acq_i});
    abs_c      = diff_c[DIFF_W-1] ? DIFF_W'(-diff_c) : DIFF_W'(diff_c);
    mismatch_d = tol_en_i ? (abs_c > {1'b0, tol_i}) : (exp_i != acq_i);
    mismatch_d = mismatch_d | unknown_c;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     mismatch_q <= 1'b0;
    else if (en_i) mismatch_q <= mismatch_d;
  end

  assign mismatch_o = mismatch_q;

endmodule

// File: rtl/sauria_stream_checker.sv
// Joins an expected-word stream with an acquired-word stream, compares the
// words lane by lane and accumulates a saturating error count.
// Optional feature macro: STREAM_CHECKER_ERRLOG_EN (first-mismatch capture).
// Ports:
//   i_system_clk, i_system_rst   clock, asynchronous active-high reset
//   i_start, i_len, i_mode, i_tol run control, latched in IDLE on i_start
//   i_exp_* / o_exp_ready        expected-word stream
//   i_acq_* / o_acq_ready        acquired-word stream
//   o_busy, o_done               run status (done = one-cycle pulse)
//   o_errors, o_words            error count and words consumed
//   o_first_err_*                (ERRLOG only) index and lane mask of first mismatch
module sauria_stream_checker
  import sauria_pkg::*;
#(
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned LEN_W  = 24,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                       i_system_clk,
  input  logic                       i_system_rst,
  input  logic                       i_start,
  input  logic [LEN_W-1:0]           i_len,
  input  logic [1:0]                 i_mode,
  input  logic [LANE_W-1:0]          i_tol,
  input  logic                       i_exp_valid,
  output logic                       o_exp_ready,
  input  logic [DATA_W-1:0]          i_exp_data,
  input  logic                       i_acq_valid,
  output logic                       o_acq_ready,
  input  logic [DATA_W-1:0]          i_acq_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [CNT_W-1:0]           o_errors,
  output logic [LEN_W-1:0]           o_words
`ifdef STREAM_CHECKER_ERRLOG_EN
  ,
  output logic                       o_first_err_valid,
  output logic [LEN_W-1:0]           o_first_err_idx,
  output logic [DATA_W/LANE_W-1:0]   o_first_err_mask
`endif
);

  localparam int unsigned N_LANES = DATA_W / LANE_W;
  localparam int unsigned PC_W    = $clog2(N_LANES + 1);
  localparam int unsigned SUM_W   = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e          state_q, state_d;
  checker_mode_e       mode_q, mode_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LANE_W-1:0]   tol_q, tol_d;
  logic [LEN_W-1:0]    words_q, words_d;
  logic [CNT_W-1:0]    errors_q, errors_d;
  logic                v1_q;
  logic                start_c, hs_c, last_c;
  logic [N_LANES-1:0]  mask_s1;
  logic [PC_W-1:0]     pc_c, add_c;
  logic [SUM_W-1:0]    sum_c;
  logic [CNT_W-1:0]    sat_c;

  assign start_c = (state_q == IDLE) & i_start;
  // Both streams must be valid; a word is never consumed from one side alone.
  assign hs_c    = (state_q == RUN) & i_exp_valid & i_acq_valid;
  assign last_c  = hs_c & (words_q == len_q - LEN_W'(1));

  // Stage 1: per-lane compare, registered inside each lane.
  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    sauria_lane_cmp #(.LANE_W(LANE_W)) u_cmp (
      .clk_i     (i_system_clk),
      .rst_i     (i_system_rst),
      .en_i      (hs_c),
      .tol_en_i  (mode_q == MODE_TOL),
      .tol_i     (tol_q),
      .exp_i     (i_exp_data[g*LANE_W +: LANE_W]),
      .acq_i     (i_acq_data[g*LANE_W +: LANE_W]),
      .mismatch_o(mask_s1[g])
    );
  end

  // Stage 2: popcount (or word-level OR) and saturating accumulate.
  always_comb begin
    pc_c = '0;
    for (int i = 0; i < N_LANES; i++) pc_c = pc_c + PC_W'(mask_s1[i]);
    add_c = (mode_q == MODE_WORD) ? PC_W'(|mask_s1) : pc_c;
    sum_c = SUM_W'(errors_q) + SUM_W'(add_c);
    sat_c = (sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_c[CNT_W-1:0];
  end

  // Run FSM; DRAIN waits until stage 1 holds no pending word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = (i_len != '0) ? RUN : DONE;
      RUN:     if (last_c)  state_d = DRAIN;
      DRAIN:   if (!v1_q)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Run configuration and counters.
  always_comb begin
    mode_d   = mode_q;
    len_d    = len_q;
    tol_d    = tol_q;
    words_d  = words_q;
    errors_d = errors_q;
    if (start_c) begin
      mode_d   = decode_mode(i_mode);
      len_d    = i_len;
      tol_d    = i_tol;
      words_d  = '0;
      errors_d = '0;
    end else begin
      if (hs_c) words_d  = words_q + LEN_W'(1);
      if (v1_q) errors_d = sat_c;
    end
  end

  always_ff @(posedge i_system_clk or posedge i_system_rst) begin
    if (i_system_rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_WORD;
      len_q    <= '0;
      tol_q    <= '0;
      words_q  <= '0;
      errors_q <= '0;
      v1_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      tol_q    <= tol_d;
      words_q  <= words_d;
      errors_q <= errors_d;
      v1_q     <= hs_c;
    end
  end

  assign o_exp_ready = hs_c;
  assign o_acq_ready = hs_c;
  assign o_busy      = (state_q == RUN) | (state_q == DRAIN);
  assign o_done      = (state_q == DONE);
  assign o_errors    = errors_q;
  assign o_words     = words_q;

`ifdef STREAM_CHECKER_ERRLOG_EN
  logic [LEN_W-1:0]   idx1_q;
  logic               fe_valid_q, fe_valid_d;
  logic [LEN_W-1:0]   fe_idx_q, fe_idx_d;
  logic [N_LANES-1:0] fe_mask_q, fe_mask_d;

  // Capture the first word whose stage-1 mask is non-empty.
  always_comb begin
    fe_valid_d = fe_valid_q;
    fe_idx_d   = fe_idx_q;
    fe_mask_d  = fe_mask_q;
    if (start_c) begin
      fe_valid_d = 1'b0;
      fe_idx_d   = '0;
      fe_mask_d  = '0;
    end else if (v1_q && (|mask_s1) && !fe_valid_q) begin
      fe_valid_d = 1'b1;
      fe_idx_d   = idx1_q;
      fe_mask_d  = mask_s1;
    end
  end

  always_ff @(posedge i_system_clk or posedge i_system_rst) begin
    if (i_system_rst) begin
      idx1_q     <= '0;
      fe_valid_q <= 1'b0;
      fe_idx_q   <= '0;
      fe_mask_q  <= '0;
    end else begin
      if (hs_c) idx1_q <= words_q;
      fe_valid_q <= fe_valid_d;
      fe_idx_q   <= fe_idx_d;
      fe_mask_q  <= fe_mask_d;
    end
  end

  assign o_first_err_valid = fe_valid_q;
  assign o_first_err_idx   = fe_idx_q;
  assign o_first_err_mask  = fe_mask_q;
`endif

endmodule

// File: tb/tb_sauria_stream_checker.sv
// Self-checking bench for sauria_stream_checker: directed cases plus random
// runs scored against a word-list reference model. Two instances share the
// stimulus: a wide counter one and a 4-bit counter one for saturation.
module tb_sauria_stream_checker;

  localparam int unsigned DW = 128;
  localparam int unsigned LW = 16;
  localparam int unsigned NL = DW / LW;
  localparam int unsigned LENW = 16;
  localparam int MAXW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [LENW-1:0] len;
  logic [1:0]      mode;
  logic [LW-1:0]   tol;
  logic            exp_valid, acq_valid;
  logic [DW-1:0]   exp_data, acq_data;

  logic            exp_ready_a, acq_ready_a, busy_a, done_a;
  logic [31:0]     errors_a;
  logic [LENW-1:0] words_a;
  logic            exp_ready_b, acq_ready_b, busy_b, done_b;
  logic [3:0]      errors_b;
  logic [LENW-1:0] words_b;
`ifdef STREAM_CHECKER_ERRLOG_EN
  logic            fev_a, fev_b;
  logic [LENW-1:0] fei_a, fei_b;
  logic [NL-1:0]   fem_a, fem_b;
`endif

  logic [DW-1:0] exp_mem [MAXW];
  logic [DW-1:0] acq_mem [MAXW];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sauria_stream_checker #(.DATA_W(DW), .LANE_W(LW), .LEN_W(LENW), .CNT_W(32)) u_dut_a (
    .i_system_clk(clk), .i_system_rst(rst), .i_start(start), .i_len(len),
    .i_mode(mode), .i_tol(tol),
    .i_exp_valid(exp_valid), .o_exp_ready(exp_ready_a), .i_exp_data(exp_data),
    .i_acq_valid(acq_valid), .o_acq_ready(acq_ready_a), .i_acq_data(acq_data),
    .o_busy(busy_a), .o_done(done_a), .o_errors(errors_a), .o_words(words_a)
`ifdef STREAM_CHECKER_ERRLOG_EN
    , .o_first_err_valid(fev_a), .o_first_err_idx(fei_a), .o_first_err_mask(fem_a)
`endif
  );

  sauria_stream_checker #(.DATA_W(DW), .LANE_W(LW), .LEN_W(LENW), .CNT_W(4)) u_dut_b (
    .i_system_clk(clk), .i_system_rst(rst), .i_start(start), .i_len(len),
    .i_mode(mode), .i_tol(tol),
    .i_exp_valid(exp_valid), .o_exp_ready(exp_ready_b), .i_exp_data(exp_data),
    .i_acq_valid(acq_valid), .o_acq_ready(acq_ready_b), .i_acq_data(acq_data),
    .o_busy(busy_b), .o_done(done_b), .o_errors(errors_b), .o_words(words_b)
`ifdef STREAM_CHECKER_ERRLOG_EN
    , .o_first_err_valid(fev_b), .o_first_err_idx(fei_b), .o_first_err_mask(fem_b)
`endif
  );

  task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Reference: errors contributed by one word and its lane mismatch mask.
  function automatic int word_err(input int md, input int tl, input logic [DW-1:0] e,
                                  input logic [DW-1:0] a, output logic [NL-1:0] m);
    int n = 0;
    m = '0;
    for (int l = 0; l < NL; l++) begin
      int ev = $signed(e[l*LW +: LW]);
      int av = $signed(a[l*LW +: LW]);
      int d  = ev - av;
      bit mis;
      if (d < 0) d = -d;
      mis = (md == 2) ? (d > tl) : (ev != av);
      if (mis) begin m[l] = 1'b1; n++; end
    end
    return (md == 0) ? ((m != '0) ? 1 : 0) : n;
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Drive one run cycle by cycle and score every cycle against the model.
  task automatic run_one(input int rlen, input int md, input int tl, input int p_exp,
                         input int p_acq, input bit noisy_start);
    int model_err [MAXW];
    logic [NL-1:0] model_mask [MAXW];
    int hs_t [MAXW];
    int idx = 0, last_hs = -1, exp_done = -1, first_k = -1;
    int total = 0, run_err;
    bit hs_exp, seen_done = 0;
    for (int k = 0; k < rlen; k++) begin
      model_err[k] = word_err(md, tl, exp_mem[k], acq_mem[k], model_mask[k]);
      total += model_err[k];
      if (first_k < 0 && model_mask[k] != '0) first_k = k;
    end
    @(negedge clk);
    start = 1'b1; len = LENW'(rlen); mode = 2'(md); tol = LW'(tl);
    exp_valid = 1'b0; acq_valid = 1'b0;
    for (int t = 1; t < 400; t++) begin
      @(negedge clk);
      start = noisy_start ? 1'($urandom_range(1)) : 1'b0;
      exp_valid = ($urandom_range(99) < p_exp);
      acq_valid = ($urandom_range(99) < p_acq);
      exp_data  = exp_mem[(idx < rlen) ? idx : 0];
      acq_data  = acq_mem[(idx < rlen) ? idx : 0];
      #1;
      if (rlen == 0) exp_done = 1;
      else if (last_hs >= 0) exp_done = last_hs + 3;
      hs_exp = (rlen > 0) && (idx < rlen) && exp_valid && acq_valid;
      run_err = 0;
      for (int k = 0; k < idx; k++) if (hs_t[k] <= t - 2) run_err += model_err[k];
      tb_check("exp_ready", 64'(exp_ready_a), 64'(hs_exp));
      tb_check("acq_ready", 64'(acq_ready_a), 64'(hs_exp));
      tb_check("ready_b", 64'({exp_ready_b, acq_ready_b}), 64'({hs_exp, hs_exp}));
      tb_check("words", 64'(words_a), 64'(idx));
      tb_check("words_b", 64'(words_b), 64'(idx));
      tb_check("errors", 64'(errors_a), 64'(run_err));
      tb_check("errors_sat", 64'(errors_b), 64'(sat15(run_err)));
      tb_check("busy", 64'({busy_a, busy_b}),
               {2{(rlen > 0) && (exp_done < 0 || t < exp_done)}});
      tb_check("done", 64'({done_a, done_b}), {2{t == exp_done}});
      if (done_a) begin
        start = 1'b0;
        seen_done = 1;
        tb_check("final_errors", 64'(errors_a), 64'(total));
        tb_check("final_errors_sat", 64'(errors_b), 64'(sat15(total)));
        tb_check("final_words", 64'(words_a), 64'(rlen));
`ifdef STREAM_CHECKER_ERRLOG_EN
        tb_check("first_valid", 64'({fev_a, fev_b}), {2{first_k >= 0}});
        tb_check("first_idx", 64'(fei_a), 64'((first_k >= 0) ? first_k : 0));
        tb_check("first_mask", 64'(fem_a), 64'((first_k >= 0) ? model_mask[first_k] : '0));
        tb_check("first_idx_b", 64'({fei_b, fem_b}), 64'({fei_a, fem_a}));
`endif
        break;
      end
      if (hs_exp) begin
        hs_t[idx] = t;
        if (idx == rlen - 1) last_hs = t;
        idx++;
      end
    end
    start = 1'b0;
    if (!seen_done) tb_check("done_timeout", 64'(0), 64'(1));
    @(negedge clk); #1;
    tb_check("idle_after", 64'({done_a, busy_a}), 64'(0));
  endtask

  task automatic fill_random(input int n, input int pert_pct);
    for (int k = 0; k < n; k++) begin
      exp_mem[k] = {$urandom, $urandom, $urandom, $urandom};
      acq_mem[k] = exp_mem[k];
      for (int l = 0; l < NL; l++)
        if ($urandom_range(99) < pert_pct)
          acq_mem[k][l*LW +: LW] = exp_mem[k][l*LW +: LW] + LW'($urandom_range(10)) - LW'(5);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; mode = '0; tol = '0;
    exp_valid = 1'b0; acq_valid = 1'b0; exp_data = '0; acq_data = '0;
    repeat (2) @(negedge clk);
    #1;
    tb_check("reset_state", 64'({busy_a, done_a, exp_ready_a, acq_ready_a}), 64'(0));
    tb_check("reset_counts", 64'({errors_a, words_a}), 64'(0));
    rst = 1'b0;

    // Identical streams, full rate.
    fill_random(4, 0);
    run_one(4, 1, 0, 100, 100, 1'b0);

    // Lanes 0 and 5 of word 1 differ.
    fill_random(2, 0);
    acq_mem[1][0]      = ~acq_mem[1][0];
    acq_mem[1][5*LW+3] = ~acq_mem[1][5*LW+3];
    run_one(2, 1, 0, 100, 100, 1'b0);
    run_one(2, 0, 0, 100, 100, 1'b0);

    // Tolerance: +3 passes, -4 fails with tol 3.
    fill_random(1, 0);
    exp_mem[0][2*LW +: LW] = 16'd100; acq_mem[0][2*LW +: LW] = 16'd97;
    exp_mem[0][3*LW +: LW] = 16'd100; acq_mem[0][3*LW +: LW] = 16'd104;
    run_one(1, 2, 3, 100, 100, 1'b0);

    // Zero-length run.
    run_one(0, 1, 0, 100, 100, 1'b0);

    // 20 mismatching lanes saturate the 4-bit counter.
    fill_random(3, 0);
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < ((k == 2) ? 4 : NL); l++) acq_mem[k][l*LW] = ~acq_mem[k][l*LW];
    run_one(3, 1, 0, 100, 100, 1'b0);

    // Random runs: acquired valid 50% first, then fully random handshakes.
    for (int r = 0; r < 14; r++) begin
      fill_random(MAXW, 30);
      run_one($urandom_range(1, 40), $urandom_range(3), $urandom_range(6),
              (r < 7) ? 100 : $urandom_range(30, 100), (r < 7) ? 50 : $urandom_range(30, 100),
              1'(r % 2));
    end

    // Reset during a run aborts it without a done pulse.
    fill_random(10, 50);
    @(negedge clk);
    start = 1'b1; len = 16'd10; mode = 2'd1; tol = '0;
    @(negedge clk);
    start = 1'b0; exp_valid = 1'b1; acq_valid = 1'b1;
    exp_data = exp_mem[0]; acq_data = acq_mem[1];
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    tb_check("rst_counts", 64'({errors_a, words_a}), 64'(0));
    tb_check("rst_status", 64'({busy_a, done_a, exp_ready_a, errors_b}), 64'(0));
`ifdef STREAM_CHECKER_ERRLOG_EN
    tb_check("rst_errlog", 64'({fev_a, fei_a, fem_a}), 64'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      tb_check("rst_no_done", 64'({done_a, busy_a, done_b}), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
